// File: rtl/joy_md6_pkg.sv
// Shared types and constants for the Mega Drive 3/6-button joystick scanner.
// JOY_MD6_SIXBTN_EN selects the full 8-phase 6-button sequence.
package joy_md6_pkg;

  typedef enum logic [3:0] {P0, P1, P2, P3, P4, P5, P6, P7, Idle} phase_e;

  localparam int unsigned BIT_U     = 0;
  localparam int unsigned BIT_D     = 1;
  localparam int unsigned BIT_L     = 2;
  localparam int unsigned BIT_R     = 3;
  localparam int unsigned BIT_B     = 4;
  localparam int unsigned BIT_C     = 5;
  localparam int unsigned BIT_A     = 6;
  localparam int unsigned BIT_START = 7;
  localparam int unsigned BIT_Z     = 8;
  localparam int unsigned BIT_Y     = 9;
  localparam int unsigned BIT_X     = 10;
  localparam int unsigned BIT_MODE  = 11;

  // Raw pin vector order: {p9, p6, right, left, down, up}
  localparam int unsigned PIN_UP    = 0;
  localparam int unsigned PIN_DOWN  = 1;
  localparam int unsigned PIN_LEFT  = 2;
  localparam int unsigned PIN_RIGHT = 3;
  localparam int unsigned PIN_P6    = 4;
  localparam int unsigned PIN_P9    = 5;

`ifdef JOY_MD6_SIXBTN_EN
  localparam phase_e      LastPhase = P7;
  localparam int unsigned ShadowW   = 12;
`else
  localparam phase_e      LastPhase = P3;
  localparam int unsigned ShadowW   = 8;
`endif

  // Select is low on even phases, high on odd phases and while idle.
  function automatic logic sel_level(phase_e ph);
    return !(ph inside {P0, P2, P4, P6});
  endfunction

endpackage

// File: rtl/joy_md6_port_decoder.sv
// One DB9 port: 2-flop pin synchroniser, shadow button capture and atomic publish.
// JOY_MD6_SIXBTN_EN adds the P4/P5 six-button detection and Z/Y/X/Mode capture.
module joy_md6_port_decoder
  import joy_md6_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [5:0]  pins_i,
  input  phase_e      phase_i,
  input  logic        sample_i,
  input  logic        publish_i,
  output logic [11:0] btn_o,
  output logic        six_btn_o
);

  logic [5:0]         sync1_q, sync2_q;
  logic [ShadowW-1:0] shadow_q, shadow_d, btn_q;
  logic               md;

`ifdef JOY_MD6_SIXBTN_EN
  logic six_pend_q, six_pend_d, six_q;
`endif

  // Left and right both grounded with select low identifies a Mega Drive pad.
  assign md = ~(sync2_q[PIN_LEFT] | sync2_q[PIN_RIGHT]);

  always_comb begin
    shadow_d = shadow_q;
`ifdef JOY_MD6_SIXBTN_EN
    six_pend_d = six_pend_q;
`endif
    if (sample_i) begin
      case (phase_i)
        P1: shadow_d[BIT_C:BIT_U] = ~sync2_q;
        P2: begin
          shadow_d[BIT_A]     = md & ~sync2_q[PIN_P6];
          shadow_d[BIT_START] = md & ~sync2_q[PIN_P9];
        end
`ifdef JOY_MD6_SIXBTN_EN
        P4: six_pend_d = ~|sync2_q[PIN_RIGHT:PIN_UP];
        P5: shadow_d[BIT_MODE:BIT_Z] = six_pend_q ? ~sync2_q[PIN_RIGHT:PIN_UP] : 4'h0;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      shadow_q <= '0;
      btn_q    <= '0;
    end else begin
      sync1_q  <= pins_i;
      sync2_q  <= sync1_q;
      shadow_q <= shadow_d;
      if (publish_i) btn_q <= shadow_q;
    end
  end

`ifdef JOY_MD6_SIXBTN_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      six_pend_q <= 1'b0;
      six_q      <= 1'b0;
    end else begin
      six_pend_q <= six_pend_d;
      if (publish_i) six_q <= six_pend_q;
    end
  end
  assign six_btn_o = six_q;
`else
  assign six_btn_o = 1'b0;
`endif

  assign btn_o = 12'(btn_q);

endmodule

// File: rtl/joy_md6_scanner.sv
// Shared select-line sequencer driving two Mega Drive port decoders on clk_sys.
// Define JOY_MD6_SIXBTN_EN for the 8-phase 6-button sequence; default is P0..P3 only.
module joy_md6_scanner
  import joy_md6_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 384,
  parameter int unsigned IDLE_PHASES = 100
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [5:0]  joy1_pins_i,
  input  logic [5:0]  joy2_pins_i,
  output logic        joyX_p7_o,
  output logic [11:0] joy1_o,
  output logic [11:0] joy2_o,
  output logic        six_btn1_o,
  output logic        six_btn2_o,
  output logic        scan_done_o
);

  localparam int unsigned DivW  = $clog2(TICK_DIV);
  localparam int unsigned IdleW = $clog2(IDLE_PHASES + 1);

  phase_e           phase_q, phase_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic             p7_q, p7_d;
  logic             done_q;
  logic             tick, publish;

  assign tick    = (div_q == DivW'(TICK_DIV - 1));
  assign publish = tick && (phase_q == LastPhase);

  always_comb begin
    phase_d = phase_q;
    idle_d  = idle_q;
    div_d   = tick ? '0 : div_q + DivW'(1);
    if (tick) begin
      if (phase_q == LastPhase) begin
        phase_d = Idle;
        idle_d  = '0;
      end else if (phase_q == Idle) begin
        if (idle_q == IdleW'(IDLE_PHASES - 1)) begin
          phase_d = P0;
          idle_d  = '0;
        end else begin
          idle_d = idle_q + IdleW'(1);
        end
      end else begin
        phase_d = phase_e'(phase_q + 4'd1);
      end
    end
    // Registered from the next phase so select moves with the phase register.
    p7_d = sel_level(phase_d);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      phase_q <= P0;
      div_q   <= '0;
      idle_q  <= '0;
      p7_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      div_q   <= div_d;
      idle_q  <= idle_d;
      p7_q    <= p7_d;
      done_q  <= publish;
    end
  end

  joy_md6_port_decoder u_port1 (
    .clk_i     (clk_sys),
    .rst_i     (reset),
    .pins_i    (joy1_pins_i),
    .phase_i   (phase_q),
    .sample_i  (tick),
    .publish_i (publish),
    .btn_o     (joy1_o),
    .six_btn_o (six_btn1_o)
  );

  joy_md6_port_decoder u_port2 (
    .clk_i     (clk_sys),
    .rst_i     (reset),
    .pins_i    (joy2_pins_i),
    .phase_i   (phase_q),
    .sample_i  (tick),
    .publish_i (publish),
    .btn_o     (joy2_o),
    .six_btn_o (six_btn2_o)
  );

  assign joyX_p7_o   = p7_q;
  assign scan_done_o = done_q;

endmodule

// File: tb/tb_joy_md6_scanner.sv
// Self-checking bench: behavioural pads on both ports, expected words from pad type and buttons.
// Follows JOY_MD6_SIXBTN_EN the same way the design does.
module tb_joy_md6_scanner;

  localparam int unsigned TickDiv = 4;
  localparam int unsigned IdlePh  = 2;
`ifdef JOY_MD6_SIXBTN_EN
  localparam int unsigned NumPh   = 8;
  localparam int unsigned RstPh   = 5;
  localparam bit          SixEn   = 1'b1;
`else
  localparam int unsigned NumPh   = 4;
  localparam int unsigned RstPh   = 3;
  localparam bit          SixEn   = 1'b0;
`endif
  localparam int unsigned Period    = (NumPh + IdlePh) * TickDiv;
  localparam int unsigned FirstDone = NumPh * TickDiv;

  typedef enum int {KNone, KMs, K3, K6} pad_e;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [5:0]  pins1, pins2;
  logic        p7;
  logic [11:0] joy1, joy2;
  logic        six1, six2, done;

  int unsigned checks = 0;
  int unsigned failures = 0;

  pad_e        kind1, kind2;
  logic [11:0] btn1, btn2;
  int unsigned lows = 0;
  int unsigned hi_cnt = 0;
  logic        sel_prev = 1'b1;

  always #5 clk_sys = ~clk_sys;

  joy_md6_scanner #(
    .TICK_DIV    (TickDiv),
    .IDLE_PHASES (IdlePh)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .joy1_pins_i (pins1),
    .joy2_pins_i (pins2),
    .joyX_p7_o   (p7),
    .joy1_o      (joy1),
    .joy2_o      (joy2),
    .six_btn1_o  (six1),
    .six_btn2_o  (six2),
    .scan_done_o (done)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pad behaviour: n counts select falling edges since the pad last timed out.
  function automatic logic [5:0] pad_pins(pad_e k, logic [11:0] b, logic sel, int unsigned n);
    case (k)
      KMs: return ~b[5:0];
      K3, K6: begin
        if (k == K6 && n == 3)
          return sel ? {~b[5], ~b[4], ~b[11], ~b[10], ~b[9], ~b[8]} : {~b[7], ~b[6], 4'b0000};
        return sel ? ~b[5:0] : {~b[7], ~b[6], 2'b00, ~b[1], ~b[0]};
      end
      default: return 6'h3F;
    endcase
  endfunction

  function automatic logic [11:0] exp_word(pad_e k, logic [11:0] b);
    case (k)
      KMs:     return b & 12'h03F;
      K3:      return b & 12'h0FF;
      K6:      return SixEn ? b : (b & 12'h0FF);
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic exp_six(pad_e k);
    return SixEn && (k == K6);
  endfunction

  // A d-pad cannot press opposite directions together.
  function automatic logic [11:0] rand_btn();
    logic [11:0] b;
    b = 12'($urandom);
    if (b[0] && b[1]) b[1] = 1'b0;
    if (b[2] && b[3]) b[3] = 1'b0;
    return b;
  endfunction

  always_comb begin
    pins1 = pad_pins(kind1, btn1, p7, lows);
    pins2 = pad_pins(kind2, btn2, p7, lows);
  end

  always @(negedge clk_sys) begin
    sel_prev <= p7;
    if (p7) begin
      hi_cnt <= hi_cnt + 1;
      if (hi_cnt >= 8) lows <= 0;
    end else begin
      hi_cnt <= 0;
      if (sel_prev) lows <= lows + 1;
    end
  end

  task automatic wait_done(output int unsigned waited, output bit held);
    logic [11:0] j1, j2;
    logic        s1, s2;
    j1 = joy1; j2 = joy2; s1 = six1; s2 = six2;
    held   = 1'b1;
    waited = 0;
    for (int i = 0; i < 3 * Period; i++) begin
      @(negedge clk_sys);
      waited++;
      if (done) return;
      if (joy1 !== j1 || joy2 !== j2 || six1 !== s1 || six2 !== s2) held = 1'b0;
    end
    check_val("scan_done_timeout", 32'(done), 32'd1);
  endtask

  task automatic expect_scan(input string tag, input int unsigned exp_wait);
    int unsigned w;
    bit          held;
    wait_done(w, held);
    check_val({tag, ".period"}, w, exp_wait);
    check_val({tag, ".hold"}, 32'(held), 32'd1);
    check_val({tag, ".joy1"}, 32'(joy1), 32'(exp_word(kind1, btn1)));
    check_val({tag, ".joy2"}, 32'(joy2), 32'(exp_word(kind2, btn2)));
    check_val({tag, ".six1"}, 32'(six1), 32'(exp_six(kind1)));
    check_val({tag, ".six2"}, 32'(six2), 32'(exp_six(kind2)));
  endtask

  initial begin
    reset = 1'b1;
    kind1 = KNone; kind2 = KNone;
    btn1  = '0;    btn2  = '0;
    repeat (3) @(negedge clk_sys);
    check_val("rst.p7", 32'(p7), 32'd1);
    check_val("rst.joy1", 32'(joy1), 32'd0);
    check_val("rst.joy2", 32'(joy2), 32'd0);
    check_val("rst.six", 32'({six1, six2}), 32'd0);
    check_val("rst.done", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge clk_sys);
    check_val("p0_sel_low", 32'(p7), 32'd0);
    expect_scan("disc", FirstDone - 1);

    kind1 = K3;  btn1 = 12'h090;
    expect_scan("md3_b_start", Period);
    kind1 = K6;  btn1 = 12'h420;
    expect_scan("md6_x_c", Period);
    kind1 = KMs; btn1 = 12'h021;
    expect_scan("sms_u_p9", Period);
    kind1 = KNone;
    expect_scan("unplug", Period);

    for (int i = 0; i < 12; i++) begin
      kind1 = pad_e'($urandom_range(3));
      kind2 = pad_e'($urandom_range(3));
      btn1  = rand_btn();
      btn2  = rand_btn();
      expect_scan("rnd", Period);
    end

    kind1 = K6; btn1 = 12'hA56;
    kind2 = K3; btn2 = 12'h0B9;
    expect_scan("pre_rst", Period);
    repeat ((IdlePh + RstPh) * TickDiv - 1) @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    check_val("midrst.joy1", 32'(joy1), 32'd0);
    check_val("midrst.joy2", 32'(joy2), 32'd0);
    check_val("midrst.six", 32'({six1, six2}), 32'd0);
    check_val("midrst.done", 32'(done), 32'd0);
    check_val("midrst.p7", 32'(p7), 32'd1);
    repeat (9) @(negedge clk_sys);
    reset = 1'b0;
    expect_scan("post_rst", FirstDone);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
